event_counter: RTL and testbench

EVENT_COUNTER -- requirements
Module: event_counter

---
 rtl/event_counter.sv | 239 +++++++++++++++++++++++
 tb/tb_event_counter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/event_counter.sv
// Up/down event counter driven by two raw push buttons, with range modes, clear, hold and wrap pulse.
// Optional debounce FSMs are compiled in with EVENT_COUNTER_DEBOUNCE_EN; otherwise steps come from edge detection.
module event_counter #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_dn,
    input  logic        clr,
    input  logic        hold,
    input  logic [1:0]  mode,
    output logic [13:0] cnt1,
    output logic [1:0]  mod_sel,
    output logic        valid,
    output logic        dp_en,
    output logic [1:0]  dp_sel,
    output logic        wrap
);

    localparam int unsigned CNT_W = 14;
    localparam int          NBTN  = 2;

    localparam logic [CNT_W-1:0] MAX_M0 = CNT_W'(255);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(99);
    localparam logic [CNT_W-1:0] MAX_M2 = CNT_W'(9999);

    if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_db_range_err
        $error("event_counter: DB_CYCLES must be within 2..65535");
    end

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q;
    logic [NBTN-1:0] sync2_q;
    logic [NBTN-1:0] step_c;

    assign btn_raw = {btn_dn, btn_up};

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef EVENT_COUNTER_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DB_CYCLES);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_e;

    db_state_e       state_q  [NBTN];
    db_state_e       state_d  [NBTN];
    logic [DB_W-1:0] db_cnt_q [NBTN];
    logic [DB_W-1:0] db_cnt_d [NBTN];
    logic [NBTN-1:0] step_q;
    logic [NBTN-1:0] step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBTN; i++) begin
                state_q[i]  <= IDLE;
                db_cnt_q[i] <= '0;
            end
            step_q <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                state_q[i]  <= state_d[i];
                db_cnt_q[i] <= db_cnt_d[i];
            end
            step_q <= step_d;
        end
    end

    // The IDLE exit sample counts as the first of the DB_CYCLES stable samples.
    always_comb begin
        step_d = '0;
        for (int i = 0; i < NBTN; i++) begin
            state_d[i]  = state_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i]  = PRESS_WAIT;
                        db_cnt_d[i] = DB_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i]  = IDLE;
                        db_cnt_d[i] = '0;
                    end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                        state_d[i]  = PRESSED;
                        db_cnt_d[i] = '0;
                        step_d[i]   = 1'b1;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                    end
                end
                PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i]  = REL_WAIT;
                        db_cnt_d[i] = DB_W'(1);
                    end
                end
                REL_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i]  = PRESSED;
                        db_cnt_d[i] = '0;
                    end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                        state_d[i]  = IDLE;
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                    end
                end
                default: begin
                    state_d[i]  = IDLE;
                    db_cnt_d[i] = '0;
                end
            endcase
        end
    end

    assign step_c = step_q;
`else
    logic [NBTN-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync2_q;
        end
    end

    assign step_c = sync2_q & ~prev_q;
`endif

    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       mod_sel_q, mod_sel_d;
    logic             valid_q,   valid_d;
    logic             wrap_q,    wrap_d;
    logic             dp_en_q,   dp_en_d;
    logic             started_q, started_d;
    logic [CNT_W-1:0] max_c;

    function automatic logic [CNT_W-1:0] max_of(input logic [1:0] m);
        case (m)
            2'd0:    max_of = MAX_M0;
            2'd1:    max_of = MAX_M1;
            2'd2:    max_of = MAX_M2;
            default: max_of = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mod_sel_q <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            dp_en_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mod_sel_q <= mod_sel_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            dp_en_q   <= dp_en_d;
            started_q <= started_d;
        end
    end

    // Priority: first-cycle load, mode change, clr, hold, then steps.
    always_comb begin
        cnt_d     = cnt_q;
        mod_sel_d = mod_sel_q;
        valid_d   = valid_q;
        wrap_d    = 1'b0;
        dp_en_d   = hold;
        started_d = 1'b1;
        max_c     = max_of(mod_sel_q);

        if (!started_q) begin
            mod_sel_d = mode;
            cnt_d     = '0;
            valid_d   = (mode != 2'd3);
        end else if (mode != mod_sel_q) begin
            mod_sel_d = mode;
            cnt_d     = '0;
            valid_d   = 1'b0;
        end else begin
            valid_d = (mod_sel_q != 2'd3);
            if (mod_sel_q == 2'd3) begin
                cnt_d = '0;
            end else if (clr) begin
                cnt_d = '0;
            end else if (!hold) begin
                case (step_c)
                    2'b01: begin
                        if (cnt_q >= max_c) begin
                            cnt_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    2'b10: begin
                        if (cnt_q == '0) begin
                            cnt_d  = max_c;
                            wrap_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: cnt_d = cnt_q;
                endcase
            end
        end
    end

    assign cnt1    = cnt_q;
    assign mod_sel = mod_sel_q;
    assign valid   = valid_q;
    assign wrap    = wrap_q;
    assign dp_en   = dp_en_q;
    assign dp_sel  = 2'd3;

endmodule

// File: tb/tb_event_counter.sv
// Directed self-checking bench for event_counter with DB_CYCLES=4; follows EVENT_COUNTER_DEBOUNCE_EN.
module tb_event_counter;

    localparam int unsigned DB = 4;
`ifdef EVENT_COUNTER_DEBOUNCE_EN
    localparam int LAT = DB + 3;
    localparam int BOUNCE_STEPS = 1;
    localparam int PW_TICKS = 4;
`else
    localparam int LAT = 3;
    localparam int BOUNCE_STEPS = 8;
    localparam int PW_TICKS = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_up;
    logic        btn_dn;
    logic        clr;
    logic        hold;
    logic [1:0]  mode;
    logic [13:0] cnt1;
    logic [1:0]  mod_sel;
    logic        valid;
    logic        dp_en;
    logic [1:0]  dp_sel;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    event_counter #(.DB_CYCLES(DB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .clr     (clr),
        .hold    (hold),
        .mode    (mode),
        .cnt1    (cnt1),
        .mod_sel (mod_sel),
        .valid   (valid),
        .dp_en   (dp_en),
        .dp_sel  (dp_sel),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up, input logic dn);
        btn_up = up;
        btn_dn = dn;
        repeat (LAT) tick();
    endtask

    task automatic release_btns();
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (LAT + 3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        clr    = 1'b0;
        hold   = 1'b0;
        mode   = 2'd1;
        #3;
        check("rst_cnt1",    32'(cnt1),    32'd0);
        check("rst_mod_sel", 32'(mod_sel), 32'd0);
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_wrap",    32'(wrap),    32'd0);
        check("rst_dp_en",   32'(dp_en),   32'd0);
        check("rst_dp_sel",  32'(dp_sel),  32'd3);

        // First edge after reset loads mode without a mode-change cycle.
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("first_mod_sel", 32'(mod_sel), 32'd1);
        check("first_valid",   32'(valid),   32'd1);
        mode = 2'd0;
        tick();
        check("mchg0_mod_sel", 32'(mod_sel), 32'd0);
        check("mchg0_valid",   32'(valid),   32'd0);
        tick();
        check("mchg0_valid_back", 32'(valid), 32'd1);

        // Clean press held 20 cycles: exactly one increment at the latency edge.
        btn_up = 1'b1;
        repeat (LAT - 1) tick();
        check("lat_before", 32'(cnt1), 32'd0);
        tick();
        check("lat_at", 32'(cnt1), 32'd1);
        check("lat_wrap", 32'(wrap), 32'd0);
        repeat (20 - LAT) tick();
        check("held_no_more", 32'(cnt1), 32'd1);
        release_btns();
        check("after_release", 32'(cnt1), 32'd1);

        // Bouncing button: toggle every 2 cycles for 30 cycles, then hold high.
        for (int i = 0; i < 30; i++) begin
            btn_up = (((i >> 1) & 1) == 0);
            tick();
        end
        btn_up = 1'b1;
        repeat (LAT + 2) tick();
        release_btns();
        check("bounce", 32'(cnt1), 32'(1 + BOUNCE_STEPS));

        press(1'b0, 1'b1);
        check("down_step", 32'(cnt1), 32'(BOUNCE_STEPS));
        release_btns();

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt1", 32'(cnt1), 32'd0);
        check("clr_wrap", 32'(wrap), 32'd0);

        // Mode 0 wraps both ways.
        press(1'b0, 1'b1);
        check("m0_dn_wrap_cnt", 32'(cnt1), 32'd255);
        check("m0_dn_wrap",     32'(wrap), 32'd1);
        tick();
        check("m0_wrap_pulse", 32'(wrap), 32'd0);
        release_btns();
        press(1'b1, 1'b0);
        check("m0_up_wrap_cnt", 32'(cnt1), 32'd0);
        check("m0_up_wrap",     32'(wrap), 32'd1);
        release_btns();
        press(1'b0, 1'b1);
        release_btns();
        for (int i = 0; i < 55; i++) begin
            press(1'b0, 1'b1);
            release_btns();
        end
        check("m0_200", 32'(cnt1), 32'd200);

        mode = 2'd1;
        tick();
        check("mchg1_cnt1",    32'(cnt1),    32'd0);
        check("mchg1_mod_sel", 32'(mod_sel), 32'd1);
        check("mchg1_valid",   32'(valid),   32'd0);
        tick();
        check("mchg1_valid_back", 32'(valid), 32'd1);

        press(1'b0, 1'b1);
        check("m1_dn_cnt", 32'(cnt1), 32'd99);
        tick();
        check("m1_dn_wrap_clear", 32'(wrap), 32'd0);
        release_btns();
        press(1'b1, 1'b0);
        check("m1_up_cnt",  32'(cnt1), 32'd0);
        check("m1_up_wrap", 32'(wrap), 32'd1);
        tick();
        check("m1_up_wrap_clear", 32'(wrap), 32'd0);
        release_btns();
        press(1'b0, 1'b1);
        check("m1_dn2_cnt",  32'(cnt1), 32'd99);
        check("m1_dn2_wrap", 32'(wrap), 32'd1);
        release_btns();

        mode = 2'd2;
        tick();
        check("mchg2_cnt1", 32'(cnt1), 32'd0);
        tick();
        press(1'b0, 1'b1);
        check("m2_dn_cnt",  32'(cnt1), 32'd9999);
        check("m2_dn_wrap", 32'(wrap), 32'd1);
        release_btns();

        hold = 1'b1;
        tick();
        check("hold_dp_en", 32'(dp_en), 32'd1);
        press(1'b1, 1'b0);
        repeat (3) tick();
        check("hold_cnt",  32'(cnt1), 32'd9999);
        check("hold_wrap", 32'(wrap), 32'd0);
        release_btns();
        hold = 1'b0;
        tick();
        check("unhold_dp_en", 32'(dp_en), 32'd0);
        press(1'b1, 1'b0);
        check("m2_up_cnt",  32'(cnt1), 32'd0);
        check("m2_up_wrap", 32'(wrap), 32'd1);
        release_btns();

        // Up and down steps land in the same cycle.
        press(1'b1, 1'b1);
        check("both_cnt",  32'(cnt1), 32'd0);
        check("both_wrap", 32'(wrap), 32'd0);
        repeat (3) tick();
        release_btns();
        check("both_after", 32'(cnt1), 32'd0);

        mode = 2'd3;
        tick();
        check("m3_valid_first", 32'(valid), 32'd0);
        tick();
        check("m3_valid_held", 32'(valid), 32'd0);
        press(1'b1, 1'b0);
        check("m3_cnt",   32'(cnt1),  32'd0);
        check("m3_wrap",  32'(wrap),  32'd0);
        check("m3_valid", 32'(valid), 32'd0);
        release_btns();

        mode = 2'd0;
        repeat (2) tick();
        check("m0_again_valid", 32'(valid), 32'd1);

        // Reset while the up button is mid-debounce.
        btn_up = 1'b1;
        repeat (PW_TICKS) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt1",    32'(cnt1),    32'd0);
        check("mid_rst_valid",   32'(valid),   32'd0);
        check("mid_rst_wrap",    32'(wrap),    32'd0);
        check("mid_rst_mod_sel", 32'(mod_sel), 32'd0);
        check("mid_rst_dp_sel",  32'(dp_sel),  32'd3);
        btn_up = 1'b0;
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 3) tick();
        check("post_rst_no_step", 32'(cnt1),  32'd0);
        check("post_rst_valid",   32'(valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
